// File: rtl/dfx_dm_pkg.sv
// Shared state encoding and parameter ranges for the BRAM <-> arbiter datamovers.
package dfx_dm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_REQ  = 3'd3,
        ST_DONE = 3'd4
    } dm_state_e;

    localparam int unsigned DM_RD_LAT_MIN  = 1;
    localparam int unsigned DM_RD_LAT_MAX  = 4;
    localparam int unsigned DM_TIMEOUT_MIN = 1;
    localparam int unsigned DM_TIMEOUT_MAX = 65536;

    // Out-of-range parameters are pulled to the nearest legal value rather than breaking elaboration.
    function automatic int unsigned dm_clamp_latency(input int unsigned lat);
        if (lat < DM_RD_LAT_MIN) return DM_RD_LAT_MIN;
        if (lat > DM_RD_LAT_MAX) return DM_RD_LAT_MAX;
        return lat;
    endfunction

    function automatic int unsigned dm_clamp_timeout(input int unsigned cyc);
        if (cyc < DM_TIMEOUT_MIN) return DM_TIMEOUT_MIN;
        if (cyc > DM_TIMEOUT_MAX) return DM_TIMEOUT_MAX;
        return cyc;
    endfunction

endpackage

// File: rtl/dm_rd_latency_pipe.sv
// Valid shift register matching the BRAM read latency; o_strobe marks the cycle read data is valid.
module dm_rd_latency_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    output logic o_strobe
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_strobe = r_pipe[DEPTH-1];

endmodule

// File: rtl/bram2arbiter_datamover.sv
// Burst mover: reads BRAM words one at a time and writes each through an arbiter request/grant port.
// Optional grant-wait timeout enabled by defining BRAM2ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start_i; burst parameters latched on accept
// RD      | bram_en high for one cycle at bram_addr
// WAIT    | BRAM read latency; capture read data on the last cycle
// REQ     | wr_req high with stable addr/data until granted (or timed out)
// DONE    | done_o pulse, then back to IDLE
module bram2arbiter_datamover
    import dfx_dm_pkg::*;
#(
    parameter int unsigned AXI_ADDRWIDTH   = 36,
    parameter int unsigned BRAM_ADDRWIDTH  = 10,
    parameter int unsigned DATAWIDTH       = 1024,
    parameter int unsigned LENWIDTH        = 8,
    parameter int unsigned BRAM_RD_LATENCY = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [AXI_ADDRWIDTH-1:0]  src_addr_i,
    input  logic [BRAM_ADDRWIDTH-1:0] dst_addr_i,
    input  logic [LENWIDTH-1:0]       len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      wr_req,
    input  logic                      wr_gnt,
    output logic [BRAM_ADDRWIDTH-1:0] wr_addr,
    output logic [DATAWIDTH-1:0]      wr_data,
    output logic [AXI_ADDRWIDTH-1:0]  bram_addr,
    output logic                      bram_en,
    output logic                      bram_we,
    input  logic [DATAWIDTH-1:0]      bram_rddata
);

    localparam int unsigned LAT = dm_clamp_latency(BRAM_RD_LATENCY);

    dm_state_e                 r_state;
    logic [LENWIDTH-1:0]       r_len;
    logic [LENWIDTH-1:0]       r_beat;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;
    logic                      r_wr_req;
    logic                      r_bram_en;
    logic [BRAM_ADDRWIDTH-1:0] r_wr_addr;
    logic [DATAWIDTH-1:0]      r_wr_data;
    logic [AXI_ADDRWIDTH-1:0]  r_bram_addr;
    logic                      w_capture;
    logic                      w_grant;
    logic                      w_timeout;

    dm_rd_latency_pipe #(
        .DEPTH (LAT)
    ) u_rd_latency_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (r_bram_en),
        .o_strobe (w_capture)
    );

    assign w_grant = r_wr_req && wr_gnt;

`ifdef BRAM2ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC = dm_clamp_timeout(TIMEOUT_CYCLES);
    localparam int          TO_W   = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Down-counter reloads whenever we are outside REQ, so every beat gets a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= TO_W'(TO_CYC - 1);
        end else if (r_state != ST_REQ) begin
            r_to_cnt <= TO_W'(TO_CYC - 1);
        end else if (!w_grant && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_REQ) && !w_grant && (r_to_cnt == '0);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_beat      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wr_req    <= 1'b0;
            r_bram_en   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_bram_addr <= '0;
        end else begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bram_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_bram_addr <= src_addr_i;
                        r_wr_addr   <= dst_addr_i;
                        r_len       <= len_i;
                        r_beat      <= '0;
                        r_bram_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_wr_data <= bram_rddata;
                        r_wr_req  <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_grant) begin
                        r_wr_req <= 1'b0;
                        if (r_beat == r_len) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_beat      <= r_beat + LENWIDTH'(1);
                            r_wr_addr   <= r_wr_addr + BRAM_ADDRWIDTH'(1);
                            r_bram_addr <= r_bram_addr + AXI_ADDRWIDTH'(1);
                            r_bram_en   <= 1'b1;
                            r_state     <= ST_RD;
                        end
                    end else if (w_timeout) begin
                        r_wr_req <= 1'b0;
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_wr_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign wr_req    = r_wr_req;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign bram_addr = r_bram_addr;
    assign bram_en   = r_bram_en;
    assign bram_we   = 1'b0;

endmodule

// File: tb/tb_bram2arbiter_datamover.sv
// Self-checking bench for bram2arbiter_datamover; timeout scenario runs when BRAM2ARB_TIMEOUT_EN is defined.
module tb_bram2arbiter_datamover;

    localparam int AW  = 36;
    localparam int BW  = 10;
    localparam int DW  = 64;
    localparam int LW  = 8;
    localparam int LAT = 1;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] src_addr_i = '0;
    logic [BW-1:0] dst_addr_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, err_o, wr_req, bram_en, bram_we;
    logic          wr_gnt = 1'b0;
    logic [BW-1:0] wr_addr;
    logic [DW-1:0] wr_data, bram_rddata;
    logic [AW-1:0] bram_addr;

    bram2arbiter_datamover #(
        .AXI_ADDRWIDTH(AW), .BRAM_ADDRWIDTH(BW), .DATAWIDTH(DW), .LENWIDTH(LW),
        .BRAM_RD_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr),
        .wr_data(wr_data), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_we(bram_we), .bram_rddata(bram_rddata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'hA5A5_5A5A, a[35:32], 28'h0ABCDEF};
    endfunction

    // BRAM model: data for an enabled address appears LAT cycles later.
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (bram_en) rd_pipe[0] <= mem_f(bram_addr);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rddata = rd_pipe[LAT-1];

    int checks = 0;
    int failures = 0;

    task automatic fail_msg(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) fail_msg(name, act, exp);
        else checks++;
    endtask

    // Scoreboard queues filled when a burst is launched
    logic [AW-1:0] rdq[$];
    logic [BW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];

    int            grant_cnt = 0, done_cnt = 0, err_cnt = 0;
    int            req_age = 0, last_run = 0, gnt_delay = 0;
    bit            spurious = 1'b0, prev_hs = 1'b0;
    logic [BW-1:0] hold_addr, last_wr_addr;
    logic [DW-1:0] hold_data;

    // Arbiter model and monitor: decides wr_gnt for the coming edge and scores each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_gnt  = 1'b0;
            req_age = 0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) check_eq("wr_req_drop", wr_req, 1'b0);
            prev_hs = 1'b0;
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
            if (bram_en) begin
                check_eq("bram_we", bram_we, 1'b0);
                if (rdq.size() == 0) fail_msg("bram_rd_unexpected", bram_addr, 0);
                else check_eq("bram_addr", bram_addr, rdq.pop_front());
            end
            if (wr_req) begin
                if (req_age == 0) begin
                    hold_addr = wr_addr;
                    hold_data = wr_data;
                end else begin
                    check_eq("wr_addr_stable", wr_addr, hold_addr);
                    check_eq("wr_data_stable", wr_data, hold_data);
                end
                if (req_age >= gnt_delay) begin
                    wr_gnt = 1'b1;
                    grant_cnt++;
                    last_wr_addr = wr_addr;
                    if (wq_addr.size() == 0) begin
                        fail_msg("grant_unexpected", wr_addr, 0);
                    end else begin
                        check_eq("wr_addr", wr_addr, wq_addr.pop_front());
                        check_eq("wr_data", wr_data, wq_data.pop_front());
                    end
                    prev_hs = 1'b1;
                    req_age = 0;
                end else begin
                    wr_gnt = 1'b0;
                    req_age++;
                end
            end else begin
                if (req_age > 0) last_run = req_age;
                req_age = 0;
                wr_gnt  = spurious;
            end
        end
    end

    task automatic push_burst(input logic [AW-1:0] s, input logic [BW-1:0] d, input int len);
        for (int i = 0; i <= len; i++) begin
            rdq.push_back(s + AW'(i));
            wq_addr.push_back(d + BW'(i));
            wq_data.push_back(mem_f(s + AW'(i)));
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0 && err_cnt == e0) fail_msg("burst_end_timeout", n, 3000);
        @(negedge clk);
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [BW-1:0] d, input logic [LW-1:0] len);
        @(negedge clk);
        start_i    = 1'b1;
        src_addr_i = s;
        dst_addr_i = d;
        len_i      = len;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] src;
        logic [BW-1:0] dst;
        logic [LW-1:0] len;
        int            gdly;
        bit            spur;
        int            exp_grants;
        logic [BW-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] lat_exp[1:5];

    initial begin
        int g0, d0, e0, n;
        vecs[0] = '{36'h10,          10'h003, 8'd0, 0, 1'b0, 1, 10'h003};
        vecs[1] = '{36'h20,          10'h003, 8'd3, 3, 1'b1, 4, 10'h006};
        vecs[2] = '{36'h40,          10'h3FE, 8'd2, 0, 1'b0, 3, 10'h000};
        vecs[3] = '{36'hF_FFFF_FFFF, 10'h100, 8'd1, 1, 1'b1, 2, 10'h101};
        vecs[4] = '{36'h55,          10'h3FF, 8'd0, 2, 1'b0, 1, 10'h3FF};
        vecs[5] = '{36'h1000,        10'h080, 8'd7, 0, 1'b1, 8, 10'h087};
        // {bram_en, wr_req, done_o, busy_o} per cycle after start, L=1, immediate grant
        lat_exp[1] = 4'b1001;
        lat_exp[2] = 4'b0001;
        lat_exp[3] = 4'b0101;
        lat_exp[4] = 4'b0011;
        lat_exp[5] = 4'b0000;

        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_outputs", {busy_o, done_o, err_o, wr_req, bram_en, bram_we}, 6'b0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_bram_addr", bram_addr, 0);

        // Latency sequence; start is presented on the very first edge after reset release.
        @(negedge clk);
        @(negedge clk);
        push_burst(36'h10, 10'h3, 0);
        d0 = done_cnt;
        rst_n      = 1'b1;
        start_i    = 1'b1;
        src_addr_i = 36'h10;
        dst_addr_i = 10'h3;
        len_i      = 8'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            check_eq($sformatf("lat_c%0d", k), {bram_en, wr_req, done_o, busy_o}, lat_exp[k]);
            if (k == 3) begin
                check_eq("lat_wr_addr", wr_addr, 10'h3);
                check_eq("lat_wr_data", wr_data, mem_f(36'h10));
            end
        end
        check_eq("lat_done_count", done_cnt - d0, 1);
        check_eq("lat_queue_empty", wq_addr.size(), 0);

        foreach (vecs[v]) begin
            gnt_delay = vecs[v].gdly;
            spurious  = vecs[v].spur;
            push_burst(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
            g0 = grant_cnt;
            d0 = done_cnt;
            e0 = err_cnt;
            launch(vecs[v].src, vecs[v].dst, vecs[v].len);
            wait_end(d0, e0);
            check_eq($sformatf("v%0d_grants", v), grant_cnt - g0, vecs[v].exp_grants);
            check_eq($sformatf("v%0d_dones", v), done_cnt - d0, 1);
            check_eq($sformatf("v%0d_last_addr", v), last_wr_addr, vecs[v].exp_last);
            check_eq($sformatf("v%0d_rd_left", v), rdq.size(), 0);
            check_eq($sformatf("v%0d_wr_left", v), wq_addr.size(), 0);
        end
        spurious = 1'b0;

        // Reset pulsed while beat 2 is waiting for its grant
        gnt_delay = 2;
        push_burst(36'h80, 10'h10, 3);
        g0 = grant_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(36'h80, 10'h10, 8'd3);
        n = 0;
        while (!((grant_cnt - g0 == 2) && wr_req && !wr_gnt) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) fail_msg("rst_mid_reach_timeout", n, 500);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outputs", {busy_o, done_o, err_o, wr_req, bram_en}, 5'b0);
        check_eq("rst_mid_wr_addr", wr_addr, 0);
        check_eq("rst_mid_bram_addr", bram_addr, 0);
        rdq.delete();
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_done", done_cnt - d0, 0);
        check_eq("rst_mid_no_err", err_cnt - e0, 0);
        gnt_delay = 1;
        push_burst(36'h300, 10'h2A, 1);
        g0 = grant_cnt;
        d0 = done_cnt;
        launch(36'h300, 10'h2A, 8'd1);
        wait_end(d0, e0);
        check_eq("post_rst_grants", grant_cnt - g0, 2);
        check_eq("post_rst_dones", done_cnt - d0, 1);
        check_eq("post_rst_wr_left", wq_addr.size(), 0);

        // start_i re-asserted while busy must not launch a second burst
        gnt_delay = 4;
        push_burst(36'h200, 10'h20, 1);
        g0 = grant_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(36'h200, 10'h20, 8'd1);
        @(negedge clk);
        start_i    = 1'b1;
        src_addr_i = 36'h999;
        dst_addr_i = 10'h1AA;
        len_i      = 8'd5;
        repeat (6) @(negedge clk);
        start_i = 1'b0;
        wait_end(d0, e0);
        check_eq("busy_start_grants", grant_cnt - g0, 2);
        check_eq("busy_start_dones", done_cnt - d0, 1);
        repeat (10) @(negedge clk);
        check_eq("busy_start_no_extra", done_cnt - d0, 1);
        check_eq("busy_start_idle", busy_o, 1'b0);
        check_eq("busy_start_rd_left", rdq.size(), 0);

`ifdef BRAM2ARB_TIMEOUT_EN
        gnt_delay = 1000000;
        push_burst(36'h400, 10'h50, 0);
        d0 = done_cnt;
        e0 = err_cnt;
        launch(36'h400, 10'h50, 8'd0);
        wait_end(d0, e0);
        check_eq("to_err_pulses", err_cnt - e0, 1);
        check_eq("to_no_done", done_cnt - d0, 0);
        check_eq("to_req_cycles", last_run, TO);
        check_eq("to_wr_req_low", wr_req, 1'b0);
        check_eq("to_busy_low", busy_o, 1'b0);
        @(negedge clk);
        check_eq("to_err_one_cycle", err_o, 1'b0);
        rdq.delete();
        wq_addr.delete();
        wq_data.delete();
        gnt_delay = 0;
        check_eq("err_total", err_cnt, 1);
`else
        check_eq("err_total", err_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram2arbiter_datamover.md
BRAM2ARBITER_DATAMOVER -- requirements
Module: bram2arbiter_datamover

Interface
REQ-001 Parameter AXI_ADDRWIDTH, default 36, width of the BRAM-side address.
REQ-002 Parameter BRAM_ADDRWIDTH, default 10, width of the arbiter-side address.
REQ-003 Parameter DATAWIDTH, default 1024, data word width.
REQ-004 Parameter LENWIDTH, default 8, burst-length field width.
REQ-005 Parameter BRAM_RD_LATENCY, default 1, legal range 1..4; BRAM read latency in cycles.
REQ-006 Parameter TIMEOUT_CYCLES, default 1024, grant-wait limit; used only under BRAM2ARB_TIMEOUT_EN.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start_i  in  1  launch a burst; sampled only in IDLE.
REQ-010 src_addr_i  in  AXI_ADDRWIDTH  first BRAM word address.
REQ-011 dst_addr_i  in  BRAM_ADDRWIDTH  first arbiter word address.
REQ-012 len_i  in  LENWIDTH  beats minus one (0 = 1 beat).
REQ-013 busy_o  out  1  high from the cycle after start is accepted until IDLE is re-entered.
REQ-014 done_o  out  1  one-cycle pulse on burst completion.
REQ-015 err_o  out  1  one-cycle pulse on timeout abort; constant 0 without the macro.
REQ-016 wr_req  out  1  arbiter write request.
REQ-017 wr_gnt  in  1  arbiter write grant.
REQ-018 wr_addr  out  BRAM_ADDRWIDTH  arbiter write address.
REQ-019 wr_data  out  DATAWIDTH  arbiter write data, registered.
REQ-020 bram_addr  out  AXI_ADDRWIDTH  BRAM read address.
REQ-021 bram_en  out  1  BRAM enable.
REQ-022 bram_we  out  1  BRAM write enable; constant 0.
REQ-023 bram_rddata  in  DATAWIDTH  BRAM read data.

Function
REQ-024 The FSM SHALL use states IDLE, RD, WAIT, REQ, DONE, with all outputs registered.
REQ-025 IDLE->RD on start_i; src_addr_i, dst_addr_i and len_i are latched and the beat counter is cleared.
REQ-026 RD: bram_en=1 for exactly one cycle at bram_addr, then go to WAIT.
REQ-027 WAIT: hold BRAM_RD_LATENCY cycles after the bram_en cycle, capture bram_rddata into wr_data on the last one, then go to REQ.
REQ-028 REQ: wr_req=1 with wr_addr and wr_data held stable until wr_req&&wr_gnt is sampled high; wr_req=0 the next cycle.
REQ-029 On grant: if beat==len, go to DONE; otherwise increment bram_addr, wr_addr and beat by 1, then go to RD.
REQ-030 Address increments SHALL wrap modulo 2^width without any flag.
REQ-031 DONE: done_o=1 for one cycle, then go to IDLE.
REQ-032 wr_gnt outside REQ SHALL be ignored; start_i outside IDLE SHALL be ignored.
REQ-033 Latency, 1 beat, L=BRAM_RD_LATENCY, immediate grant: start at cycle 0; bram_en at 1; capture at 1+L; wr_req at 2+L; done_o at 3+L.
REQ-034 A burst of len_i+1 beats SHALL produce exactly len_i+1 grants and exactly one done_o.

Reset
REQ-035 While rst_n=0, all outputs and registers SHALL be 0 and the state SHALL be IDLE; reset mid-burst aborts with no done_o or err_o.
REQ-036 The first start_i SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-037 With BRAM2ARB_TIMEOUT_EN defined: a counter runs while in REQ without a grant; after TIMEOUT_CYCLES cycles, drop wr_req, pulse err_o for one cycle, go to IDLE, and do not pulse done_o.
REQ-038 Without BRAM2ARB_TIMEOUT_EN: no counter; err_o tied 0; REQ waits indefinitely.

Structure
REQ-039 Package dfx_dm_pkg SHALL hold the state enum and the latency and timeout range constants shared with arbiter2bram_datamover.
REQ-040 There SHALL be one sub-module, dm_rd_latency_pipe: a shift-register valid pipe of depth BRAM_RD_LATENCY that generates the capture strobe.

Verification
REQ-041 len_i=0, src=0x10, dst=0x3, immediate grant, L=1 -> bram_en at cycle 1, wr_req at 3 with wr_addr=0x3 and wr_data=mem[0x10], done_o at 4.
REQ-042 len_i=3, grant delayed 3 cycles per beat -> 4 grants on wr_addr 0x3..0x6 with matching data, one done_o.
REQ-043 dst=0x3FE, len_i=2 -> wr_addr sequence 0x3FE, 0x3FF, 0x000.
REQ-044 rst_n pulsed low during REQ of beat 2 -> all outputs 0 asynchronously, no done_o, new burst runs cleanly afterwards.
REQ-045 start_i asserted while busy_o=1 -> ignored; exactly one done_o.
REQ-046 Macro on, TIMEOUT_CYCLES=16, wr_gnt held 0 -> err_o pulse after 16 REQ cycles, wr_req=0, no done_o.
